// File: rtl/mips_pkg.sv
// Shared definitions for the data cache: FSM state encoding
// and word geometry constants.
package mips_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    MEM_RD,
    MEM_WR
  } state_t;

endpackage

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through no-allocate data cache.
// Ports: cache_* request/response side, mem_* fixed-latency memory side.
module data_cache
  import mips_pkg::*;
#(
  parameter int NUM_LINES   = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               cache_read,
  input  logic                               cache_write,
  input  logic [WORD_W-1:0]                  cache_addr,
  input  logic [WORD_W-1:0]                  cache_write_data,
  output logic [WORD_W-1:0]                  cache_load_data,
  output logic                               cache_ready,
  output logic [WORD_W-1:0]                  mem_addr,
  output logic [BYTES_PER_WORD-1:0][7:0]     mem_data_in,
  output logic                               mem_write_en,
  input  logic [BYTES_PER_WORD-1:0][7:0]     mem_data_out
);

  localparam int IDX = $clog2(NUM_LINES);
  localparam int TW  = WORD_W - 2 - IDX;
  localparam int CW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t state, next;

  logic [CW-1:0]        cnt;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tags [NUM_LINES];
  logic [WORD_W-1:0]    data [NUM_LINES];

  logic [IDX-1:0]    idx;
  logic [TW-1:0]     tag;
  logic [WORD_W-1:0] waddr;
  logic              hit;
  logic              last;
  logic              unused_lsb;

  assign idx        = cache_addr[IDX+1:2];
  assign tag        = cache_addr[WORD_W-1:IDX+2];
  assign waddr      = {cache_addr[WORD_W-1:2], 2'b00};
  assign hit        = valid[idx] && (tags[idx] == tag);
  assign last       = (cnt == '0);
  assign unused_lsb = ^cache_addr[1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (cache_write)     next = MEM_WR;
        else if (cache_read) next = hit ? RESP : MEM_RD;
      end
      MEM_RD:  if (last) next = RESP;
      MEM_WR:  if (last) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt             <= '0;
      cache_ready     <= 1'b0;
      cache_load_data <= '0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      mem_write_en    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cache_write) begin
            cnt          <= CW'(MEM_LATENCY - 1);
            mem_addr     <= waddr;
            mem_data_in  <= cache_write_data;
            mem_write_en <= 1'b1;
          end else if (cache_read) begin
            if (hit) begin
              cache_ready     <= 1'b1;
              cache_load_data <= data[idx];
            end else begin
              cnt      <= CW'(MEM_LATENCY - 1);
              mem_addr <= waddr;
            end
          end
        end
        MEM_RD: begin
          if (last) begin
            mem_addr        <= '0;
            cache_ready     <= 1'b1;
            cache_load_data <= mem_data_out;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MEM_WR: begin
          if (last) begin
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            cache_ready  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    cache_ready <= 1'b0;
        default: cache_ready <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                         valid      <= '0;
    else if (state == MEM_RD && last)   valid[idx] <= 1'b1;
  end

  // Write hits refresh the line; write misses leave it alone.
  always_ff @(posedge clk) begin
    if (state == MEM_RD && last) begin
      tags[idx] <= tag;
      data[idx] <= mem_data_out;
    end else if (state == MEM_WR && last && hit) begin
      data[idx] <= cache_write_data;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against an
// array-based reference cache and a word-addressed memory.
module tb_data_cache;

  localparam int LAT = 4;
  localparam int NL  = 32;

  logic            clk = 0;
  logic            rst_b = 0;
  logic            cache_read = 0;
  logic            cache_write = 0;
  logic [31:0]     cache_addr = 0;
  logic [31:0]     cache_write_data = 0;
  logic [31:0]     cache_load_data;
  logic            cache_ready;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic            mem_write_en;
  logic [3:0][7:0] mem_data_out;

  data_cache #(.NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_write_data(cache_write_data),
    .cache_load_data(cache_load_data), .cache_ready(cache_ready),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign mem_data_out = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (mem_write_en) mem[mem_addr[9:2]] <= mem_data_in;

  bit          r_valid [NL];
  logic [31:0] r_word  [NL];
  logic [31:0] r_data  [NL];
  logic [31:0] r_load;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < NL; i++) r_valid[i] = 0;
    r_load = 0;
  endtask

  // Issue one request, observe it to completion, compare with the model.
  task automatic do_req(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int cyc = 0, we_cyc = 0, ma_cyc = 0;
    bit ma_ok = 1, md_ok = 1, done = 0;
    int w = int'(a[31:2]);
    int li = w % NL;
    bit hit = r_valid[li] && (r_word[li] == a[31:2]);
    logic [31:0] mword = mem[a[9:2]];
    int exp_cyc;
    @(negedge clk);
    cache_read = rd; cache_write = wr;
    cache_addr = a;  cache_write_data = wd;
    while (!done && cyc < 50) begin
      @(posedge clk); #1; cyc++;
      if (mem_write_en) begin
        we_cyc++;
        if (mem_data_in !== wd) md_ok = 0;
      end
      if (mem_addr != 0) begin
        ma_cyc++;
        if (mem_addr !== {a[31:2], 2'b00}) ma_ok = 0;
      end
      if (cache_ready) done = 1;
    end
    cache_read = 0; cache_write = 0;
    check("done", 32'(done), 32'd1);
    if (wr) begin
      exp_cyc = LAT + 1;
      if (hit) r_data[li] = wd;
      check("wr_we", we_cyc, LAT);
      check("wr_ma", ma_cyc, LAT);
      check("wr_bytes", 32'(md_ok), 1);
    end else if (hit) begin
      exp_cyc = 1;
      r_load = r_data[li];
      check("hit_ma", ma_cyc, 0);
    end else begin
      exp_cyc = LAT + 1;
      r_valid[li] = 1;
      r_word[li] = a[31:2];
      r_data[li] = mword;
      r_load = mword;
      check("miss_ma", ma_cyc, LAT);
      check("miss_we", we_cyc, 0);
    end
    check("lat", cyc, exp_cyc);
    check("addr", 32'(ma_ok), 1);
    check("load", cache_load_data, r_load);
    @(posedge clk); #1;
    check("ready_1cyc", 32'(cache_ready), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ld"}, cache_load_data, 0);
    check({tag, "_rdy"}, 32'(cache_ready), 0);
    check({tag, "_ma"}, mem_addr, 0);
    check({tag, "_md"}, mem_data_in, 0);
    check({tag, "_we"}, 32'(mem_write_en), 0);
  endtask

  initial begin
    bit rd, wr;
    int seen;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[16] = 32'h1234_5678;
    ref_reset();
    #12;
    check_zero("rst");
    @(negedge clk); rst_b = 1;

    do_req(1, 0, 32'h40, 0);
    check("d_first", cache_load_data, 32'h1234_5678);
    do_req(1, 0, 32'h40, 0);
    do_req(0, 1, 32'h40, 32'hDEAD_BEEF);
    do_req(1, 0, 32'h40, 0);
    check("d_wrhit", cache_load_data, 32'hDEAD_BEEF);
    do_req(1, 0, 32'hC0, 0);
    do_req(1, 0, 32'h40, 0);
    do_req(0, 1, 32'h80, 32'hCAFE_0001);
    do_req(1, 0, 32'h80, 0);
    check("d_noalloc", cache_load_data, 32'hCAFE_0001);
    do_req(1, 1, 32'h42, 32'h0BAD_F00D);
    check("d_both", cache_load_data, 32'hCAFE_0001);

    // Reset in the second memory cycle of a read miss.
    @(negedge clk);
    cache_read = 1; cache_addr = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 0; #1;
    check_zero("arst");
    cache_read = 0;
    ref_reset();
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (cache_ready) seen++;
    end
    check("arst_noresp", seen, 0);
    @(negedge clk); rst_b = 1;
    do_req(1, 0, 32'h104, 0);

    for (int t = 0; t < 200; t++) begin
      int op = $urandom_range(0, 9);
      rd = (op < 6) || (op == 9);
      wr = (op >= 6);
      a = {22'd0, 8'($urandom_range(1, 95)), 2'($urandom)};
      do_req(rd, wr, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_LINES, default 32, number of direct-mapped one-word lines; power of two, at least 2.
REQ-002 Parameter MEM_LATENCY, default 4, memory access time in cycles; at least 1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_b  in  1  asynchronous, active-low reset.
REQ-005 cache_read  in  1  load request from control unit.
REQ-006 cache_write  in  1  store request from control unit.
REQ-007 cache_addr  in  32  byte address of request; bits [1:0] ignored.
REQ-008 cache_write_data  in  32  store data.
REQ-009 cache_load_data  out  32  load result; valid when cache_ready=1.
REQ-010 cache_ready  out  1  one-cycle completion pulse.
REQ-011 mem_addr  out  32  word-aligned memory address, bits [1:0]=0.
REQ-012 mem_data_in  out  4x8  store bytes to memory; element 0 = bits [7:0] (little-endian).
REQ-013 mem_write_en  out  1  memory write strobe.
REQ-014 mem_data_out  in  4x8  memory read bytes; element 0 = bits [7:0].

Function
REQ-015 Address split: index = addr[IDX+1:2], IDX = log2(NUM_LINES); tag = addr[31:IDX+2]; each line holds valid bit, tag, 32-bit data.
REQ-016 FSM states: IDLE, RESP, MEM_RD, MEM_WR.
REQ-017 IDLE samples requests on each edge; cache_write=1 goes to MEM_WR (write wins when both are set); cache_read hit goes to RESP; cache_read miss goes to MEM_RD.
REQ-018 Read hit: cache_load_data = line data and cache_ready=1 during the RESP cycle, i.e. one cycle after sampling; no memory activity.
REQ-019 MEM_RD: mem_addr = {addr[31:2],2'b00} for MEM_LATENCY cycles, counted by a down-counter.
REQ-020 At the last MEM_RD cycle, mem_data_out is captured into the line, valid=1 and tag are written, and the FSM goes to RESP, which returns the captured word.
REQ-021 Write is write-through, no-write-allocate.
REQ-022 MEM_WR: mem_addr is driven, mem_data_in = cache_write_data bytes, and mem_write_en=1 for exactly MEM_LATENCY cycles; on a hit the line data is updated at the last cycle; on a miss the line is untouched; then RESP.
REQ-023 RESP lasts exactly one cycle with cache_ready=1, then returns to IDLE.
REQ-024 Requests present during RESP are ignored.
REQ-025 The requester holds addr, data and request stable until the cache_ready pulse and deasserts in the cycle after it.
REQ-026 cache_load_data holds its last read value between reads; a write response does not alter it.
REQ-027 Outside MEM_RD/MEM_WR: mem_write_en=0 and mem_addr=0.
REQ-028 Outside MEM_WR: mem_data_in = 0.
REQ-029 All outputs are registered.

Reset
REQ-030 rst_b=0 immediately forces state IDLE, all valid bits 0, counter 0, cache_ready=0, cache_load_data=0, mem_addr=0, mem_data_in=0, mem_write_en=0.
REQ-031 Reset during MEM_RD/MEM_WR aborts the access; no line is updated and no cache_ready pulse follows.
REQ-032 Line data and tag arrays need not be reset.

Structure
REQ-033 Shared package mips_pkg holds the FSM state enum and constants WORD_W=32 and BYTES_PER_WORD=4.
REQ-034 No sub-module; the line arrays are inferred inside data_cache.

Verification (NUM_LINES=32, MEM_LATENCY=4)
REQ-035 Read 0x40 after reset, memory bytes {78,56,34,12}: mem_addr=0x40 for 4 cycles, then cache_ready with load data 0x12345678; a repeat read gives ready next cycle with no memory access.
REQ-036 Write 0xDEADBEEF to 0x40 after REQ-035: mem_write_en high for 4 cycles with bytes {EF,BE,AD,DE}; the following read of 0x40 hits and returns 0xDEADBEEF.
REQ-037 Read 0x40, then 0xC0 (both index 16): the second read misses and evicts; a re-read of 0x40 misses again.
REQ-038 Write miss to 0x80, then read 0x80: the write does not allocate and the read misses (4-cycle memory access).
REQ-039 cache_read=cache_write=1 at 0x40: a write is performed (mem_write_en high 4 cycles) and cache_load_data is unchanged.
REQ-040 rst_b pulsed low in cycle 2 of a read miss: outputs zero at once, no cache_ready, and a later read of the same address misses.
